// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift arbiter slice.
//   SHIFT_ARB_MAX_NREQ  - largest number of issue slots the arbiter supports
//   SHIFT_*_WIDTH       - default operand / shift amount / tag widths
//   shift_op_t          - one shift operation as presented by an issue slot
//   shift_grant_index() - encodes a one-hot grant vector to a slot index
// -----------------------------------------------------------------------------
package shift_pkg;

   localparam int SHIFT_ARB_MAX_NREQ = 4;
   localparam int SHIFT_DATA_WIDTH   = 32;
   localparam int SHIFT_SHAMT_WIDTH  = 5;
   localparam int SHIFT_TAG_WIDTH    = 6;

   typedef struct packed {
      logic [SHIFT_DATA_WIDTH-1:0]  data;
      logic [SHIFT_SHAMT_WIDTH-1:0] shamt;
      logic                         shleft;
      logic                         sharith;
      logic [SHIFT_TAG_WIDTH-1:0]   tag;
   } shift_op_t;

   // One-hot to index. An all-zero vector encodes to 0; callers only use the
   // result when some grant bit is set.
   function automatic int shift_grant_index(input logic [SHIFT_ARB_MAX_NREQ-1:0] grant);
      int idx;
      idx = 0;
      for (int i = 0; i < SHIFT_ARB_MAX_NREQ; i++) begin
         if (grant[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// -----------------------------------------------------------------------------
// shifter
// Purely combinational barrel shifter shared by all issue slots.
//   data    in  DATA_WIDTH   operand
//   shamt   in  SHAMT_WIDTH  unsigned shift amount (all bits significant)
//   shleft  in  1            1 = shift left, 0 = shift right
//   sharith in  1            1 = arithmetic; only affects right shifts
//   result  out DATA_WIDTH   shifted value
// Left shifts always zero-fill; arithmetic right shifts replicate the MSB.
// -----------------------------------------------------------------------------
module shifter #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic [DATA_WIDTH-1:0]  data,
   input  logic [SHAMT_WIDTH-1:0] shamt,
   input  logic                   shleft,
   input  logic                   sharith,
   output logic [DATA_WIDTH-1:0]  result
);

   always_comb begin
      result = '0;
      if (shleft)
         result = data << shamt;
      else if (sharith)
         result = $signed(data) >>> shamt;
      else
         result = data >> shamt;
   end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
// Shares one combinational shifter between NREQ issue slots. One slot is
// granted per cycle; its shifted result is registered, so latency is exactly
// one cycle, and the stage sustains one operation per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands stable until accepted; ready
// never depends combinationally on the slot's own operands, only on
// req_valid, the pointer, flush, reset and the result-side state.
//
// Configuration macro SHIFT_ARB_RR_EN:
//   defined   - round-robin: search starts at the pointer, upward with wrap.
//   undefined - fixed priority: lowest valid index wins; no pointer register.
//
// Ports
//   clock, reset     single clock, synchronous active-high reset
//   flush            drop in-flight result, accept nothing this cycle
//   req_valid/ready  per-slot handshake (at most one ready bit set)
//   req_in/shamt/shleft/sharith/tag   per-slot operation
//   res_valid/ready  result handshake
//   res_data/tag/id  shifted value, tag and granted slot index
// -----------------------------------------------------------------------------
module shift_arbiter
   import shift_pkg::*;
#(
   parameter  int NREQ        = 2,
   parameter  int DATA_WIDTH  = SHIFT_DATA_WIDTH,
   parameter  int SHAMT_WIDTH = SHIFT_SHAMT_WIDTH,
   parameter  int TAG_WIDTH   = SHIFT_TAG_WIDTH,
   localparam int IDW         = $clog2(NREQ)
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              flush,
   input  logic [NREQ-1:0]                   req_valid,
   output logic [NREQ-1:0]                   req_ready,
   input  logic [NREQ-1:0][DATA_WIDTH-1:0]   req_in,
   input  logic [NREQ-1:0][SHAMT_WIDTH-1:0]  req_shamt,
   input  logic [NREQ-1:0]                   req_shleft,
   input  logic [NREQ-1:0]                   req_sharith,
   input  logic [NREQ-1:0][TAG_WIDTH-1:0]    req_tag,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [DATA_WIDTH-1:0]             res_data,
   output logic [TAG_WIDTH-1:0]              res_tag,
   output logic [IDW-1:0]                    res_id
);

   logic                          free;
   logic                          accept;
   logic                          fire;
   logic [NREQ-1:0]               grant;
   logic [SHIFT_ARB_MAX_NREQ-1:0] grant_ext;
   logic [IDW-1:0]                gidx;
   int                            base;
   shift_op_t                     op;
   logic [DATA_WIDTH-1:0]         shift_result;

`ifdef SHIFT_ARB_RR_EN
   logic [IDW-1:0] ptr;

   assign base = int'(ptr);

   // Pointer moves past the winner only on a real handshake; flush and
   // backpressure leave it alone because fire is already qualified by both.
   always_ff @(posedge clock) begin
      if (reset)
         ptr <= '0;
      else if (fire)
         ptr <= IDW'((int'(gidx) + 1) % NREQ);
   end
`else
   assign base = 0;
`endif

   // The result register can take a new value if it is empty or being drained.
   assign free   = !res_valid || res_ready;
   assign accept = free && !flush && !reset;

   // First valid slot starting at base, with wrap-around. With base = 0 this
   // degenerates to fixed lowest-index priority.
   always_comb begin
      grant = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant == '0 && req_valid[(base + k) % NREQ])
            grant[(base + k) % NREQ] = 1'b1;
      end
   end

   always_comb begin
      grant_ext            = '0;
      grant_ext[NREQ-1:0]  = grant;
      gidx                 = IDW'(shift_grant_index(grant_ext));
   end

   assign req_ready = accept ? grant : '0;
   assign fire      = |req_ready;

   // Operand mux feeding the single shared shifter.
   always_comb begin
      op.data    = SHIFT_DATA_WIDTH'(req_in[gidx]);
      op.shamt   = SHIFT_SHAMT_WIDTH'(req_shamt[gidx]);
      op.shleft  = req_shleft[gidx];
      op.sharith = req_sharith[gidx];
      op.tag     = SHIFT_TAG_WIDTH'(req_tag[gidx]);
   end

   shifter #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHAMT_WIDTH (SHAMT_WIDTH)
   ) u_shifter (
      .data    (DATA_WIDTH'(op.data)),
      .shamt   (SHAMT_WIDTH'(op.shamt)),
      .shleft  (op.shleft),
      .sharith (op.sharith),
      .result  (shift_result)
   );

   // Reset beats flush beats load beats drain. A load while draining simply
   // replaces the register, so res_valid stays high with no bubble.
   always_ff @(posedge clock) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
         res_id    <= '0;
      end else if (flush) begin
         res_valid <= 1'b0;
      end else if (fire) begin
         res_valid <= 1'b1;
         res_data  <= shift_result;
         res_tag   <= TAG_WIDTH'(op.tag);
         res_id    <= gidx;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic [1:0]       req_valid = '0;
   logic [1:0]       req_ready;
   logic [1:0][31:0] req_in = '0;
   logic [1:0][4:0]  req_shamt = '0;
   logic [1:0]       req_shleft = '0;
   logic [1:0]       req_sharith = '0;
   logic [1:0][5:0]  req_tag = '0;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic [31:0]      res_data;
   logic [5:0]       res_tag;
   logic [0:0]       res_id;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural reference state
   bit          m_valid;
   logic [31:0] m_data;
   logic [5:0]  m_tag;
   int          m_id;
   int          m_ptr;
   logic [31:0] exp_q[$];

   shift_arbiter dut (
      .clock(clock), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in(req_in), .req_shamt(req_shamt),
      .req_shleft(req_shleft), .req_sharith(req_sharith), .req_tag(req_tag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_tag(res_tag), .res_id(res_id)
   );

   always #5 clock = ~clock;

   // Shift expressed as multiply/divide by a power of two.
   function automatic logic [31:0] shift_ref(logic [31:0] v, int s, bit left, bit arith);
      longint unsigned p = 1;
      longint unsigned x = {32'b0, v};
      longint unsigned nx = {32'b0, ~v};
      longint unsigned prod;
      for (int i = 0; i < s; i++) p = p * 2;
      if (left) begin
         prod = x * p;
         return prod[31:0];
      end
      if (arith && v[31]) begin
         prod = nx / p;
         return ~prod[31:0];
      end
      prod = x / p;
      return prod[31:0];
   endfunction

   function automatic int pick(logic [1:0] vld);
      int start;
`ifdef SHIFT_ARB_RR_EN
      start = m_ptr;
`else
      start = 0;
`endif
      for (int k = 0; k < 2; k++) begin
         if (vld[(start + k) % 2]) return (start + k) % 2;
      end
      return -1;
   endfunction

   function automatic logic [1:0] model_ready();
      logic [1:0] r;
      int w;
      r = '0;
      if (reset || flush || (m_valid && !res_ready)) return r;
      w = pick(req_valid);
      if (w >= 0) r[w] = 1'b1;
      return r;
   endfunction

   task automatic model_update();
      logic [1:0] r;
      int w;
      r = model_ready();
      if (reset) begin
         m_valid = 0; m_data = '0; m_tag = '0; m_id = 0; m_ptr = 0;
         exp_q.delete();
      end else begin
         if (m_valid && (flush || res_ready) && exp_q.size() > 0) void'(exp_q.pop_front());
         if (flush) begin
            m_valid = 0;
         end else if (r != 2'b00) begin
            w = r[1] ? 1 : 0;
            m_data  = shift_ref(req_in[w], int'(req_shamt[w]), req_shleft[w], req_sharith[w]);
            m_tag   = req_tag[w];
            m_id    = w;
            m_ptr   = (w + 1) % 2;
            m_valid = 1;
            exp_q.push_back(m_data);
         end else if (res_ready) begin
            m_valid = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_update();
      #1;
   endtask

   task automatic set_op(int s, logic [31:0] d, int sh, bit l, bit a, logic [5:0] t);
      req_in[s]      = d;
      req_shamt[s]   = 5'(sh);
      req_shleft[s]  = l;
      req_sharith[s] = a;
      req_tag[s]     = t;
   endtask

   task automatic rand_op(int s);
      set_op(s, $urandom, $urandom_range(0, 31), 1'($urandom), 1'($urandom), 6'($urandom));
   endtask

   task automatic apply_reset();
      reset = 1; flush = 0; req_valid = '0; res_ready = 0;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; req_valid = 2'b11; res_ready = 1;
      rand_op(0); rand_op(1);
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
      tick();
      tick();
      n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
      n_checks++; if (res_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 0", res_data); end
      n_checks++; if (res_tag !== 6'h0 || res_id !== 1'b0) begin n_errors++; $display("FAIL reset_tag_id: got %h/%h expected 0/0", res_tag, res_id); end
      reset = 0; req_valid = '0;
   endtask

   task automatic test_single_op();
      set_op(0, 32'h8000_0001, 4, 1'b0, 1'b1, 6'd5);
      req_valid = 2'b01; res_ready = 1;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
      tick();
      n_checks++; if (res_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %b expected 1", res_valid); end
      n_checks++; if (res_data !== 32'hF800_0000 || res_data !== m_data) begin n_errors++; $display("FAIL single_data: got %h expected f8000000 (model %h)", res_data, m_data); end
      n_checks++; if (res_tag !== 6'd5 || res_id !== 1'b0) begin n_errors++; $display("FAIL single_tag_id: got %0d/%0d expected 5/0", res_tag, res_id); end
      req_valid = '0;
      #1;
      tick();
      n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL single_drain: got %b expected 0", res_valid); end
   endtask

   task automatic test_contention();
      int exp_id;
      apply_reset();
      rand_op(0); rand_op(1);
      req_valid = 2'b11; res_ready = 1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++; if ($countones(req_ready) != 1 || req_ready !== model_ready()) begin n_errors++; $display("FAIL cont_ready[%0d]: got %b expected %b", c, req_ready, model_ready()); end
         tick();
`ifdef SHIFT_ARB_RR_EN
         exp_id = c % 2;
`else
         exp_id = 0;
`endif
         n_checks++; if (int'(res_id) != exp_id || res_valid !== 1'b1) begin n_errors++; $display("FAIL cont_id[%0d]: got %0d expected %0d", c, res_id, exp_id); end
         n_checks++; if (res_data !== m_data || res_tag !== m_tag) begin n_errors++; $display("FAIL cont_data[%0d]: got %h/%h expected %h/%h", c, res_data, res_tag, m_data, m_tag); end
         rand_op(m_id);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      apply_reset();
      rand_op(0);
      req_valid = 2'b01; res_ready = 0;
      #1;
      tick();
      held = m_data;
      rand_op(1);
      req_valid = 2'b10;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", c, req_ready); end
         tick();
         n_checks++; if (res_valid !== 1'b1 || res_data !== held || res_id !== 1'b0) begin n_errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%0d expected 1/%h/0", c, res_valid, res_data, res_id, held); end
      end
      res_ready = 1;
      #1;
      n_checks++; if (req_ready !== 2'b10) begin n_errors++; $display("FAIL bp_release_ready: got %b expected 10", req_ready); end
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_id !== 1'b1 || res_data !== m_data) begin n_errors++; $display("FAIL bp_release: got %b/%0d/%h expected 1/1/%h", res_valid, res_id, res_data, m_data); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_shift_edges();
      logic [31:0] din  [6];
      int          sh   [6];
      bit          left [6];
      bit          ar   [6];
      logic [31:0] exp  [6];
      logic [31:0] r;
      r = $urandom;
      din[0] = 32'hFFFF_FFFF; sh[0] = 31; left[0] = 1; ar[0] = 0; exp[0] = 32'h8000_0000;
      din[1] = 32'hFFFF_FFFF; sh[1] = 31; left[1] = 0; ar[1] = 0; exp[1] = 32'h0000_0001;
      din[2] = 32'hFFFF_FFFF; sh[2] = 31; left[2] = 0; ar[2] = 1; exp[2] = 32'hFFFF_FFFF;
      din[3] = r;             sh[3] = 0;  left[3] = 0; ar[3] = 1; exp[3] = r;
      din[4] = 32'h8000_0000; sh[4] = 31; left[4] = 0; ar[4] = 1; exp[4] = 32'hFFFF_FFFF;
      din[5] = 32'h1234_5678; sh[5] = 4;  left[5] = 1; ar[5] = 1; exp[5] = 32'h2345_6780;
      res_ready = 1;
      for (int i = 0; i < 6; i++) begin
         set_op(0, din[i], sh[i], left[i], ar[i], 6'(i));
         req_valid = 2'b01;
         #1;
         tick();
         n_checks++; if (res_data !== exp[i] || res_data !== m_data) begin n_errors++; $display("FAIL edge[%0d]: got %h expected %h (model %h)", i, res_data, exp[i], m_data); end
         req_valid = '0;
         #1;
         tick();
      end
   endtask

   task automatic test_flush();
      logic [1:0] exp_r;
      apply_reset();
      rand_op(0);
      req_valid = 2'b01; res_ready = 0;
      #1;
      tick();
      rand_op(0);
      flush = 1; res_ready = 1;
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL flush_ready: got %b expected 00", req_ready); end
      tick();
      n_checks++; if (res_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid: got %b expected 0", res_valid); end
      flush = 0;
      rand_op(1);
      req_valid = 2'b11;
`ifdef SHIFT_ARB_RR_EN
      exp_r = 2'b10;
`else
      exp_r = 2'b01;
`endif
      #1;
      n_checks++; if (req_ready !== exp_r || req_ready !== model_ready()) begin n_errors++; $display("FAIL flush_ptr: got %b expected %b", req_ready, exp_r); end
      tick();
      n_checks++; if (res_data !== m_data || int'(res_id) != m_id) begin n_errors++; $display("FAIL flush_after: got %h/%0d expected %h/%0d", res_data, res_id, m_data, m_id); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      rand_op(1);
      req_valid = 2'b10; res_ready = 0;
      #1;
      tick();
      n_checks++; if (res_valid !== 1'b1) begin n_errors++; $display("FAIL rmid_pending: got %b expected 1", res_valid); end
      reset = 1; req_valid = 2'b11; rand_op(0);
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_errors++; $display("FAIL rmid_ready: got %b expected 00", req_ready); end
      tick();
      n_checks++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_tag !== 6'h0 || res_id !== 1'b0) begin n_errors++; $display("FAIL rmid_zero: got %b/%h/%h/%0d expected all zero", res_valid, res_data, res_tag, res_id); end
      reset = 0; res_ready = 1;
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_errors++; $display("FAIL rmid_first_grant: got %b expected 01", req_ready); end
      tick();
      n_checks++; if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== m_data) begin n_errors++; $display("FAIL rmid_first_res: got %b/%0d/%h expected 1/0/%h", res_valid, res_id, res_data, m_data); end
      req_valid = '0;
      tick();
   endtask

   task automatic test_random();
      logic [1:0] last_acc;
      apply_reset();
      last_acc = '0;
      for (int c = 0; c < 300; c++) begin
         flush     = ($urandom_range(0, 19) == 0);
         res_ready = ($urandom_range(0, 9) < 7);
         for (int s = 0; s < 2; s++) begin
            if (!req_valid[s] || last_acc[s]) begin
               req_valid[s] = ($urandom_range(0, 9) < 6);
               if (req_valid[s]) begin
                  rand_op(s);
                  if ($urandom_range(0, 7) == 0) req_shamt[s] = 5'($urandom_range(0, 1) * 31);
               end
            end
         end
         #1;
         n_checks++; if (req_ready !== model_ready()) begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, req_ready, model_ready()); end
         if (res_valid && res_ready && !flush && exp_q.size() > 0) begin
            n_checks++; if (res_data !== exp_q[0]) begin n_errors++; $display("FAIL rnd_deliver[%0d]: got %h expected %h", c, res_data, exp_q[0]); end
         end
         last_acc = model_ready();
         tick();
         n_checks++; if (res_valid !== m_valid) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, res_valid, m_valid); end
         if (m_valid) begin
            n_checks++; if (res_data !== m_data || res_tag !== m_tag || int'(res_id) != m_id) begin n_errors++; $display("FAIL rnd_result[%0d]: got %h/%h/%0d expected %h/%h/%0d", c, res_data, res_tag, res_id, m_data, m_tag, m_id); end
         end
      end
      flush = 0; req_valid = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_contention();
      test_backpressure();
      test_shift_edges();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
